// File: rtl/snn_readout_pkg.sv
// Shared types and widths for the spike readout block: FSM encoding,
// class-index width and accuracy-statistics width.
package snn_readout_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    DECIDE = 2'd2,
    REPORT = 2'd3
  } state_t;

  localparam int unsigned CLASS_W = 4;
  localparam int unsigned STAT_W  = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] val);
    return (val == '1) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/onehot_to_index.sv
// One-hot (bit k = index k, k starting at 1) to binary index, with a flag
// that is high only when exactly one bit is set.
module onehot_to_index #(
  parameter int unsigned P_N     = 10,
  parameter int unsigned P_IDX_W = 4
) (
  input  logic [P_N:1]       onehot,
  output logic [P_IDX_W-1:0] index,
  output logic               valid
);

  always_comb begin
    index = '0;
    for (int unsigned k = 1; k <= P_N; k++) begin
      if (onehot[k]) index = P_IDX_W'(k);
    end
    valid = ($countones(onehot) == 1);
  end

endmodule

// File: rtl/spike_readout.sv
// Counts per-class output spikes over a fixed window, picks the winning class
// (lowest index on ties), compares it with the latched label and keeps stats.
module spike_readout
  import snn_readout_pkg::*;
#(
  parameter int unsigned P_N      = 10,
  parameter int unsigned P_WINDOW = 400,
  parameter int unsigned P_CNT_W  = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [P_N:1]        i_spike,
  input  logic [P_N:1]        i_label,
  input  logic                i_clear_stats,
  output logic                o_busy,
  output logic                o_valid,
  output logic [CLASS_W-1:0]  o_class,
  output logic                o_correct,
  output logic                o_no_spike,
  output logic [STAT_W-1:0]   o_total_cnt,
  output logic [STAT_W-1:0]   o_hit_cnt
);

  state_t               state;
  logic [P_CNT_W-1:0]   cnt [1:P_N];
  logic [P_N:1]         label_q;
  logic [15:0]          win_cnt;
  logic [CLASS_W-1:0]   scan_idx;
  logic [CLASS_W-1:0]   max_idx;
  logic [P_CNT_W-1:0]   max_val;
  logic [P_CNT_W-1:0]   cur_cnt;
  logic [CLASS_W-1:0]   label_idx;
  logic                 label_ok;
  logic                 hit_now;

  onehot_to_index #(
    .P_N     (P_N),
    .P_IDX_W (CLASS_W)
  ) u_label_idx (
    .onehot (label_q),
    .index  (label_idx),
    .valid  (label_ok)
  );

  always_comb begin
    cur_cnt = '0;
    for (int unsigned k = 1; k <= P_N; k++) begin
      if (CLASS_W'(k) == scan_idx) cur_cnt = cnt[k];
    end
    // max_idx stays 0 when nothing spiked, so a zero winner never matches
    hit_now = label_ok && (label_idx == max_idx) && (max_val != '0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      for (int unsigned k = 1; k <= P_N; k++) cnt[k] <= '0;
      label_q     <= '0;
      win_cnt     <= '0;
      scan_idx    <= '0;
      max_idx     <= '0;
      max_val     <= '0;
      o_busy      <= 1'b0;
      o_valid     <= 1'b0;
      o_class     <= '0;
      o_correct   <= 1'b0;
      o_no_spike  <= 1'b0;
      o_total_cnt <= '0;
      o_hit_cnt   <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            for (int unsigned k = 1; k <= P_N; k++) cnt[k] <= '0;
            label_q <= i_label;
            win_cnt <= 16'(P_WINDOW - 1);
            state   <= COUNT;
            o_busy  <= 1'b1;
          end
        end
        COUNT: begin
          if (i_start) begin
            for (int unsigned k = 1; k <= P_N; k++) cnt[k] <= '0;
            label_q <= i_label;
            win_cnt <= 16'(P_WINDOW - 1);
          end else begin
            for (int unsigned k = 1; k <= P_N; k++) begin
              if (i_spike[k] && (cnt[k] != '1)) cnt[k] <= cnt[k] + 1'b1;
            end
            if (win_cnt == '0) begin
              state    <= DECIDE;
              scan_idx <= CLASS_W'(1);
              max_idx  <= '0;
              max_val  <= '0;
            end else begin
              win_cnt <= win_cnt - 1'b1;
            end
          end
        end
        DECIDE: begin
          if (cur_cnt > max_val) begin
            max_val <= cur_cnt;
            max_idx <= scan_idx;
          end
          if (scan_idx == CLASS_W'(P_N)) state <= REPORT;
          else                           scan_idx <= scan_idx + 1'b1;
        end
        REPORT: begin
          o_valid     <= 1'b1;
          o_class     <= max_idx;
          o_correct   <= hit_now;
          o_no_spike  <= (max_val == '0);
          o_total_cnt <= sat_inc(o_total_cnt);
          if (hit_now) o_hit_cnt <= sat_inc(o_hit_cnt);
          state       <= IDLE;
          o_busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      // Placed after the FSM so a clear coinciding with REPORT takes priority
      if (i_clear_stats) begin
        o_total_cnt <= '0;
        o_hit_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spike_readout.sv
// Scoreboard bench for spike_readout: a behavioural model predicts each report
// when a window is driven; a negedge monitor pops and compares on o_valid.
module tb_spike_readout;

  localparam int N  = 10;
  localparam int W  = 400;
  localparam int LAT = 1 + W + N;

  logic          clk = 1'b0;
  logic          rst, start, clear;
  logic [N:1]    spike, label;
  logic          busy, valid, correct, no_spike;
  logic [3:0]    cls;
  logic [15:0]   total, hit;

  int unsigned   cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            m_total = 0;
  int            m_hit = 0;

  typedef struct {
    int cls;
    bit correct;
    bit no_spike;
    int total;
    int hit;
    int start_edge;
  } exp_t;

  typedef int narr_t [N];

  exp_t q[$];

  spike_readout #(
    .P_N      (N),
    .P_WINDOW (W),
    .P_CNT_W  (8)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_spike       (spike),
    .i_label       (label),
    .i_clear_stats (clear),
    .o_busy        (busy),
    .o_valid       (valid),
    .o_class       (cls),
    .o_correct     (correct),
    .o_no_spike    (no_spike),
    .o_total_cnt   (total),
    .o_hit_cnt     (hit)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: o_valid=1 at cycle %0d, required no report", cyc);
      end else begin
        e = q.pop_front();
        checks++;
        if (cls !== 4'(e.cls)) begin
          errors++; $display("FAIL class: got %0d, expected %0d", cls, e.cls);
        end
        checks++;
        if (correct !== e.correct) begin
          errors++; $display("FAIL correct: got %b, expected %b", correct, e.correct);
        end
        checks++;
        if (no_spike !== e.no_spike) begin
          errors++; $display("FAIL no_spike: got %b, expected %b", no_spike, e.no_spike);
        end
        checks++;
        if (total !== 16'(e.total)) begin
          errors++; $display("FAIL total_cnt: got %0d, expected %0d", total, e.total);
        end
        checks++;
        if (hit !== 16'(e.hit)) begin
          errors++; $display("FAIL hit_cnt: got %0d, expected %0d", hit, e.hit);
        end
        checks++;
        if (int'(cyc) - e.start_edge != LAT) begin
          errors++;
          $display("FAIL latency: got %0d cycles, expected %0d", int'(cyc) - e.start_edge, LAT);
        end
      end
    end
  end

  // mode 0: plain window; 1: clear_stats coinciding with REPORT; 2: start pulsed in DECIDE
  task automatic run_window(input narr_t n, input logic [N:1] lbl,
                            input logic [N:1] start_spk, input int mode);
    exp_t       e;
    logic [N:1] v;
    int         best, bidx, lidx, c, wc;
    bit         oh;
    best = 0; bidx = 0;
    for (int i = 0; i < N; i++) begin
      c = (n[i] > W) ? W : n[i];
      if (c > 255) c = 255;
      if (c > best) begin best = c; bidx = i + 1; end
    end
    oh = ($countones(lbl) == 1);
    lidx = 0;
    for (int i = 0; i < N; i++) if (lbl[i+1]) lidx = i + 1;
    e.cls      = bidx;
    e.no_spike = (bidx == 0);
    e.correct  = oh && (lidx == bidx) && (bidx != 0);
    if (mode == 1) begin
      m_total = 0; m_hit = 0;
    end else begin
      m_total++;
      if (e.correct) m_hit++;
    end
    e.total = m_total;
    e.hit   = m_hit;

    start = 1'b1; spike = start_spk; label = lbl;
    e.start_edge = int'(cyc) + 1;
    q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; label = '0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_after_start: got %b, expected 1", busy);
    end
    for (int j = 0; j < W; j++) begin
      for (int i = 0; i < N; i++) v[i+1] = (j < n[i]);
      spike = v;
      @(posedge clk); #1;
    end
    spike = '0;
    if (mode == 2) begin
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end else if (mode == 1) begin
      repeat (N) begin @(posedge clk); #1; end
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
    end
    wc = 0;
    while (q.size() != 0 && wc < 100) begin
      @(posedge clk); #1;
      wc++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL report_timeout: got no o_valid, expected a report");
      q.delete();
    end
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL busy_idle: got %b, expected 0", busy);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({busy, valid, cls, correct, no_spike, total, hit} !== '0) begin
      errors++;
      $display("FAIL %s: got busy=%b valid=%b class=%0d correct=%b no_spike=%b total=%0d hit=%0d, expected all 0",
               tag, busy, valid, cls, correct, no_spike, total, hit);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; clear = 1'b0; spike = '0; label = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst = 1'b0;
    @(posedge clk); #1;
    check_all_zero("after_reset_release");
  endtask

  task automatic test_basic();
    narr_t n = '{default: 0};
    n[2] = 5; n[6] = 2;
    run_window(n, 10'b00_0000_0100, '0, 0);
  endtask

  task automatic test_tie();
    narr_t n = '{default: 0};
    n[1] = 4; n[4] = 4;
    // class 5 spiking in the start cycle must not break the tie
    run_window(n, 10'b00_0001_0000, 10'b00_0001_0000, 0);
  endtask

  task automatic test_no_spike();
    narr_t n = '{default: 0};
    run_window(n, 10'b00_0000_0001, '0, 0);
  endtask

  task automatic test_saturation();
    narr_t n = '{default: 0};
    n[0] = 400;
    run_window(n, 10'b00_0000_0001, '0, 0);
    n = '{default: 0};
    n[0] = 100; n[1] = 300;
    run_window(n, 10'b00_0000_0010, '0, 0);
  endtask

  task automatic test_bad_label();
    narr_t n = '{default: 0};
    n[2] = 7;
    run_window(n, 10'b00_0000_1100, '0, 0);
    run_window(n, 10'b00_0000_0000, '0, 0);
  endtask

  task automatic test_abort();
    narr_t n = '{default: 0};
    start = 1'b1; label = 10'b00_0000_1000;
    @(posedge clk); #1;
    start = 1'b0; label = '0;
    spike = 10'b00_0000_1000;
    repeat (200) begin @(posedge clk); #1; end
    spike = '0;
    n[5] = 3;
    run_window(n, 10'b00_0010_0000, '0, 0);
  endtask

  task automatic test_start_in_decide();
    narr_t n = '{default: 0};
    n[8] = 9; n[9] = 2;
    run_window(n, 10'b01_0000_0000, '0, 2);
  endtask

  task automatic test_clear_report();
    narr_t n = '{default: 0};
    n[3] = 6;
    run_window(n, 10'b00_0000_1000, '0, 1);
  endtask

  task automatic test_reset_decide();
    start = 1'b1; label = 10'b00_0000_0001;
    @(posedge clk); #1;
    start = 1'b0; label = '0;
    spike = 10'b00_0000_0001;
    repeat (W) begin @(posedge clk); #1; end
    spike = '0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1 check_all_zero("reset_in_decide");
    @(posedge clk); #1;
    rst = 1'b0;
    m_total = 0; m_hit = 0;
    repeat (30) begin @(posedge clk); #1; end
    check_all_zero("idle_after_decide_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_no_spike();
    test_saturation();
    test_bad_label();
    test_abort();
    test_start_in_decide();
    test_clear_report();
    test_reset_decide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
